// File: rtl/chrono_core_param_if.sv
`default_nettype none
// ============================================================================
// chrono_core_param_if : program-load port and output stream of chrono_core_param
// Revision 1.0
// ============================================================================
interface chrono_core_param_if #(
  parameter int PROG_DEPTH = 16
);
  localparam int AW = $clog2(PROG_DEPTH);

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [2:0]    prog_data;
  logic [2:0]    out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output prog_we, prog_addr, prog_data, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, out_ready,
    output out_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/chrono_core_param.sv
`default_nettype none
// ============================================================================
// chrono_core_param : 3-bit chronospatial ISA core, loadable program RAM,
//                     generic register width and valid/ready output FIFO
// Revision 1.0
// ============================================================================
module chrono_core_param #(
  parameter int REG_W      = 48,
  parameter int PROG_DEPTH = 16,
  parameter int OUT_DEPTH  = 4,
  localparam int AW        = $clog2(PROG_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  chrono_core_param_if.slave  bus,
  input  logic [AW:0]         prog_len,
  input  logic [REG_W-1:0]    init_a,
  input  logic                start,
  output logic                busy,
  output logic                halt,
  output logic                err
);

  localparam int FW = $clog2(OUT_DEPTH);

  localparam logic [2:0] OP_ADV = 3'd0;
  localparam logic [2:0] OP_BXL = 3'd1;
  localparam logic [2:0] OP_BST = 3'd2;
  localparam logic [2:0] OP_JNZ = 3'd3;
  localparam logic [2:0] OP_BXC = 3'd4;
  localparam logic [2:0] OP_OUT = 3'd5;
  localparam logic [2:0] OP_BDV = 3'd6;
  localparam logic [2:0] OP_CDV = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t             state_q;
  logic [AW:0]        ip_q;
  logic [AW:0]        len_q;
  logic [REG_W-1:0]   a_q, b_q, c_q;
  logic [2:0]         opc_q, opr_q;
  logic               busy_q, halt_q, err_q;

  logic [2:0]         ram [PROG_DEPTH];

  logic [2:0]         fifo_q [OUT_DEPTH];
  logic [FW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FW:0]        cnt_q;

  logic [AW+1:0]      ip1;
  logic               fetch_end;
  logic               load_ok;
  logic [REG_W-1:0]   combo;
  logic               combo_used;
  logic               combo_bad;
  logic [REG_W-1:0]   shifted;
  logic               fifo_full;
  logic               pop;
  logic               push;

  assign ip1       = {1'b0, ip_q} + (AW+2)'(1);
  assign fetch_end = ip1 >= {1'b0, len_q};
  assign load_ok   = (state_q == S_IDLE) || (state_q == S_HALT);

  always_comb begin
    combo = REG_W'(opr_q);
    case (opr_q)
      3'd4:    combo = a_q;
      3'd5:    combo = b_q;
      3'd6:    combo = c_q;
      default: combo = REG_W'(opr_q);
    endcase
  end

  // bxl, jnz and bxc never interpret their operand as a combo.
  assign combo_used = (opc_q == OP_ADV) || (opc_q == OP_BST) || (opc_q == OP_OUT) ||
                      (opc_q == OP_BDV) || (opc_q == OP_CDV);
  assign combo_bad  = (state_q == S_EXEC) && combo_used && (opr_q == 3'd7);
  assign shifted    = (combo >= REG_W'(REG_W)) ? '0 : (a_q >> combo);

  assign fifo_full = cnt_q == (FW+1)'(OUT_DEPTH);
  assign pop       = (cnt_q != '0) && bus.out_ready;
  assign push      = (state_q == S_EXEC) && (opc_q == OP_OUT) && !combo_bad &&
                     (!fifo_full || pop);

  assign bus.out_valid = cnt_q != '0;
  assign bus.out_data  = fifo_q[rd_ptr_q];
  assign busy          = busy_q;
  assign halt          = halt_q;
  assign err           = err_q;

  always_ff @(posedge clk) begin
    if (bus.prog_we && load_ok) begin
      ram[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= combo[2:0];
        wr_ptr_q         <= wr_ptr_q + FW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (FW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (FW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ip_q    <= '0;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      opc_q   <= '0;
      opr_q   <= '0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
            ip_q    <= '0;
            len_q   <= prog_len;
            a_q     <= init_a;
            b_q     <= '0;
            c_q     <= '0;
          end
        end
        S_FETCH: begin
          if (fetch_end) begin
            state_q <= S_HALT;
            busy_q  <= 1'b0;
            halt_q  <= 1'b1;
          end else begin
            opc_q   <= ram[ip_q[AW-1:0]];
            opr_q   <= ram[ip1[AW-1:0]];
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (combo_bad) begin
            err_q   <= 1'b1;
            state_q <= S_HALT;
            busy_q  <= 1'b0;
            halt_q  <= 1'b1;
          end else if ((opc_q == OP_OUT) && !push) begin
            // FIFO full with no pop: retry the same out next cycle.
            state_q <= S_EXEC;
          end else begin
            state_q <= S_FETCH;
            ip_q    <= ip_q + (AW+1)'(2);
            case (opc_q)
              OP_ADV: a_q <= shifted;
              OP_BXL: b_q <= b_q ^ REG_W'(opr_q);
              OP_BST: b_q <= REG_W'(combo[2:0]);
              OP_JNZ: if (a_q != '0) ip_q <= (AW+1)'(opr_q);
              OP_BXC: b_q <= b_q ^ c_q;
              OP_BDV: b_q <= shifted;
              OP_CDV: c_q <= shifted;
              default: ;
            endcase
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chrono_core_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_chrono_core_param : scoreboard bench for chrono_core_param
// Revision 1.0
// ============================================================================
module tb_chrono_core_param;

  localparam int REG_W      = 48;
  localparam int PROG_DEPTH = 16;
  localparam int OUT_DEPTH  = 4;
  localparam int AW         = $clog2(PROG_DEPTH);

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             start  = 1'b0;
  logic [AW:0]      prog_len = '0;
  logic [REG_W-1:0] init_a = '0;
  logic             busy, halt, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_q [$];
  logic [2:0] prog  [$];
  logic [2:0] exp_p1 [10] = '{3'd4, 3'd6, 3'd3, 3'd5, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'd0};

  chrono_core_param_if #(.PROG_DEPTH(PROG_DEPTH)) bus ();

  chrono_core_param #(
    .REG_W     (REG_W),
    .PROG_DEPTH(PROG_DEPTH),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .prog_len(prog_len),
    .init_a  (init_a),
    .start   (start),
    .busy    (busy),
    .halt    (halt),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d, expected no output", bus.out_data);
      end else begin
        check("out_data", {61'd0, bus.out_data}, {61'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = AW'(i);
      bus.prog_data = prog[i];
      cyc(1);
    end
    bus.prog_we = 1'b0;
  endtask

  task automatic run(input int len, input logic [REG_W-1:0] a);
    prog_len = (AW+1)'(len);
    init_a   = a;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
  endtask

  task automatic push_p1();
    for (int i = 0; i < 10; i++) exp_q.push_back(exp_p1[i]);
  endtask

  task automatic wait_halt(input string name, input int budget);
    int k = 0;
    while (!halt && k < budget) begin
      cyc(1);
      k++;
    end
    check(name, {63'd0, halt}, 64'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.out_ready = 1'b1;

    cyc(3);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data",  {61'd0, bus.out_data},  64'd0);
    check("rst_busy",      {63'd0, busy}, 64'd0);
    check("rst_halt",      {63'd0, halt}, 64'd0);
    check("rst_err",       {63'd0, err},  64'd0);
    rst_n = 1'b1;
    cyc(1);

    // Reference program with writes attempted mid-run.
    prog = '{3'd0, 3'd1, 3'd5, 3'd4, 3'd3, 3'd0};
    load_prog();
    push_p1();
    run(6, 48'd729);
    cyc(10);
    check("t1_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < PROG_DEPTH; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = AW'(i);
      bus.prog_data = 3'd7;
      cyc(1);
    end
    bus.prog_we = 1'b0;
    wait_halt("t1_halt", 300);
    wait_drain("t1_drain", 20);
    check("t1_err",   {63'd0, err},  64'd0);
    check("t1_busy_end", {63'd0, busy}, 64'd0);
    check("t1_valid_end", {63'd0, bus.out_valid}, 64'd0);

    // Re-run from HALT: dropped writes must not have altered the program.
    push_p1();
    run(6, 48'd729);
    wait_halt("t1b_halt", 300);
    wait_drain("t1b_drain", 20);

    // Backpressure: FIFO fills, core stalls on the fifth out.
    bus.out_ready = 1'b0;
    push_p1();
    run(6, 48'd729);
    cyc(60);
    check("t2_busy_stall", {63'd0, busy}, 64'd1);
    check("t2_halt_stall", {63'd0, halt}, 64'd0);
    check("t2_valid",      {63'd0, bus.out_valid}, 64'd1);
    check("t2_head",       {61'd0, bus.out_data}, 64'd4);
    bus.out_ready = 1'b1;
    wait_halt("t2_halt", 300);
    wait_drain("t2_drain", 20);

    // Reserved combo operand.
    prog = '{3'd0, 3'd7, 3'd5, 3'd4};
    load_prog();
    run(4, 48'd5);
    wait_halt("t3_halt", 20);
    cyc(3);
    check("t3_err",   {63'd0, err}, 64'd1);
    check("t3_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t3_busy",  {63'd0, busy}, 64'd0);

    // bst A; bxl 7; out B with A = 2^47; start clears err.
    prog = '{3'd2, 3'd4, 3'd1, 3'd7, 3'd5, 3'd5};
    load_prog();
    exp_q.push_back(3'd7);
    run(6, 48'h8000_0000_0000);
    check("t4_err_cleared", {63'd0, err}, 64'd0);
    wait_halt("t4_halt", 40);
    wait_drain("t4_drain", 10);

    // adv by C=0 leaves A: out A%8 with A=13.
    prog = '{3'd0, 3'd6, 3'd5, 3'd4};
    load_prog();
    exp_q.push_back(3'd5);
    run(4, 48'd13);
    wait_halt("t5a_halt", 40);
    wait_drain("t5a_drain", 10);

    // bxl 7; bdv by A=100 (>= REG_W) -> B=0; out B.
    prog = '{3'd1, 3'd7, 3'd6, 3'd4, 3'd5, 3'd5};
    load_prog();
    exp_q.push_back(3'd0);
    run(6, 48'd100);
    wait_halt("t5b_halt", 40);
    wait_drain("t5b_drain", 10);

    // A=4660: B=4, C=291, B=295 -> outputs 7, 3.
    prog = '{3'd2, 3'd4, 3'd7, 3'd5, 3'd4, 3'd0, 3'd5, 3'd5, 3'd5, 3'd6};
    load_prog();
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd3);
    run(10, 48'd4660);
    wait_halt("t7_halt", 60);
    wait_drain("t7_drain", 10);

    // Lengths 1 and 0 halt on first fetch with no output.
    run(1, 48'd9);
    wait_halt("t8_len1_halt", 10);
    check("t8_len1_valid", {63'd0, bus.out_valid}, 64'd0);
    run(0, 48'd9);
    wait_halt("t8_len0_halt", 10);
    check("t8_len0_valid", {63'd0, bus.out_valid}, 64'd0);

    // Asynchronous reset mid-run.
    prog = '{3'd0, 3'd1, 3'd5, 3'd4, 3'd3, 3'd0};
    load_prog();
    bus.out_ready = 1'b0;
    run(6, 48'd729);
    cyc(12);
    check("t6_busy_pre",  {63'd0, busy}, 64'd1);
    check("t6_valid_pre", {63'd0, bus.out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t6_rst_data",  {61'd0, bus.out_data},  64'd0);
    check("t6_rst_busy",  {63'd0, busy}, 64'd0);
    check("t6_rst_halt",  {63'd0, halt}, 64'd0);
    check("t6_rst_err",   {63'd0, err},  64'd0);
    cyc(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc(5);
    check("t6_idle_busy", {63'd0, busy}, 64'd0);
    check("t6_idle_halt", {63'd0, halt}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
